// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: per-register countdown of cycles until a producer's result is usable by ID.
// Optional stall statistics counter is built only when HAZARD_STALL_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 2,
  parameter int WB_LAT   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic              forward_en,
  output logic              hazard_detected,
  output logic              issue,
  output logic [15:0]       stall_cycles
);

  localparam int N = 1 << REG_AW;

  logic [CNT_W-1:0] r_count [N];
  logic             w_src1_pend;
  logic             w_src2_pend;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  assign w_src1_pend     = (r_count[src1] != '0);
  assign w_src2_pend     = (r_count[src2] != '0);
  assign hazard_detected = id_valid & (w_src1_pend | (two_src & w_src2_pend));
  assign issue           = id_valid & ~hazard_detected & ~freeze & ~flush;
  assign w_load          = issue & id_wb_en;

  // With forwarding only a load's data arrives too late for the next instruction.
  always_comb begin
    w_load_val = '0;
    if (!forward_en)      w_load_val = CNT_W'(WB_LAT);
    else if (id_mem_r_en) w_load_val = CNT_W'(LOAD_LAT);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < N; i++) r_count[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < N; i++) begin
        if (w_load && (id_dest == REG_AW'(i)))
          r_count[i] <= w_load_val;
        else if (r_count[i] != '0)
          r_count[i] <= r_count[i] - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (hazard_detected && !freeze && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

`ifdef HAZARD_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid, id_wb_en, id_mem_r_en, two_src, forward_en;
  logic [3:0]  id_dest, src1, src2;
  logic        hazard_detected, issue;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic        haz;
    logic        iss;
    logic [15:0] st;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = 16'd0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .src1(src1), .src2(src2), .two_src(two_src), .forward_en(forward_en),
    .hazard_detected(hazard_detected), .issue(issue), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Monitor: compares whatever the DUT presents in each cycle that has an expectation queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{haz: hazard_detected, iss: issue, st: stall_cycles};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got haz=%b issue=%b stall=%0d, want haz=%b issue=%b stall=%0d",
                 n, a.haz, a.iss, a.st, e.haz, e.iss, e.st);
      end
    end
  end

  task automatic set_in(input bit v, input int d, input bit wb, input bit mr,
                        input int s1, input int s2, input bit two);
    id_valid    = v;
    id_dest     = 4'(d);
    id_wb_en    = wb;
    id_mem_r_en = mr;
    src1        = 4'(s1);
    src2        = 4'(s2);
    two_src     = two;
  endtask

  // Queue the expectation for the current cycle, advance the stats model, step one clock.
  task automatic cyc(input string nm, input bit eh, input bit ei);
    exp_q.push_back('{haz: eh, iss: ei, st: exp_stall});
    name_q.push_back(nm);
    if (rst) exp_stall = 16'd0;
    else if (STATS && eh && !freeze && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; forward_en = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state: nothing pending
    set_in(1, 0, 0, 0, 3, 5, 1);
    cyc("reset_state", 0, 1);

    // Forwarding off: ADD R3 then consumer of R3 -> 2 stalls, issue on 3rd
    forward_en = 1'b0;
    set_in(1, 3, 1, 0, 0, 0, 0);  cyc("add_r3", 0, 1);
    set_in(1, 0, 0, 0, 3, 0, 0);  cyc("r3_stall1", 1, 0);
    cyc("r3_stall2", 1, 0);
    cyc("r3_issue", 0, 1);

    // Forwarding on: load R5, two-source consumer -> 1 stall
    forward_en = 1'b1;
    set_in(1, 5, 1, 1, 0, 0, 0);  cyc("load_r5", 0, 1);
    set_in(1, 0, 0, 0, 0, 5, 1);  cyc("r5_src2_stall", 1, 0);
    cyc("r5_src2_issue", 0, 1);
    // Same load, but src2 unused -> no stall
    set_in(1, 5, 1, 1, 0, 0, 0);  cyc("load_r5_again", 0, 1);
    set_in(1, 0, 0, 0, 0, 5, 0);  cyc("r5_src2_unused", 0, 1);
    // ALU producer with forwarding -> no stall
    set_in(1, 7, 1, 0, 0, 0, 0);  cyc("alu_r7", 0, 1);
    set_in(1, 0, 0, 0, 7, 0, 0);  cyc("r7_no_stall", 0, 1);

    // Forwarding off: reload of a decrementing entry wins over the decrement
    forward_en = 1'b0;
    set_in(1, 3, 1, 0, 0, 0, 0);  cyc("prod_r3_a", 0, 1);
    set_in(1, 3, 1, 0, 1, 0, 0);  cyc("prod_r3_b", 0, 1);
    set_in(1, 0, 0, 0, 3, 0, 0);  cyc("reload_stall1", 1, 0);
    cyc("reload_stall2", 1, 0);
    cyc("reload_issue", 0, 1);

    // Bubble cycles still count down
    set_in(1, 8, 1, 0, 0, 0, 0);  cyc("prod_r8", 0, 1);
    set_in(0, 0, 0, 0, 8, 0, 0);  cyc("bubble1", 0, 0);
    cyc("bubble2", 0, 0);
    set_in(1, 0, 0, 0, 8, 0, 0);  cyc("r8_after_bubbles", 0, 1);

    // Freeze holds R2's count at 2 for 3 cycles, then 2 more stall cycles
    set_in(1, 2, 1, 0, 0, 0, 0);  cyc("prod_r2", 0, 1);
    set_in(1, 0, 0, 0, 2, 0, 0);
    freeze = 1'b1;
    cyc("frz1", 1, 0);
    cyc("frz2", 1, 0);
    cyc("frz3", 1, 0);
    freeze = 1'b0;
    cyc("r2_stall1", 1, 0);
    cyc("r2_stall2", 1, 0);
    cyc("r2_issue", 0, 1);
    // Freeze blocks issue even without a hazard
    freeze = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0);  cyc("frz_no_issue", 0, 0);
    freeze = 1'b0;

    // Flush clears pending R4; a producer in the flush cycle is dropped
    set_in(1, 4, 1, 0, 0, 0, 0);  cyc("prod_r4", 0, 1);
    set_in(1, 0, 0, 0, 4, 0, 0);
    flush = 1'b1;
    cyc("flush_cycle", 1, 0);
    flush = 1'b0;
    cyc("r4_after_flush", 0, 1);
    flush = 1'b1;
    set_in(1, 6, 1, 0, 0, 0, 0);  cyc("flush_prod_r6", 0, 0);
    flush = 1'b0;
    set_in(1, 0, 0, 0, 6, 0, 0);  cyc("r6_not_loaded", 0, 1);

    // Reset mid-stall releases the stall and clears stats
    set_in(1, 4, 1, 0, 0, 0, 0);  cyc("prod_r4_b", 0, 1);
    set_in(1, 0, 0, 0, 4, 0, 0);  cyc("r4_stall", 1, 0);
    rst = 1'b1;
    cyc("rst_cycle", 1, 0);
    rst = 1'b0;
    cyc("r4_after_rst", 0, 1);
    // Reset overrides a producer issuing in the same cycle
    rst = 1'b1;
    set_in(1, 9, 1, 0, 0, 0, 0);  cyc("rst_prod_r9", 0, 1);
    rst = 1'b0;
    set_in(1, 0, 0, 0, 9, 0, 0);  cyc("r9_not_loaded", 0, 1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4: register-address width; the table holds 2**REG_AW entries.
REQ-002 SHALL have parameter CNT_W, default 2: width of each entry's countdown.
REQ-003 SHALL have parameter WB_LAT, default 2: stall window for any write-back producer when forwarding is off; range 1..2**CNT_W-1.
REQ-004 SHALL have parameter LOAD_LAT, default 1: stall window for a load producer when forwarding is on; range 0..WB_LAT.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  reset, synchronous, active-high
 freeze  in  1  pipeline frozen (memory wait); table holds its state
 flush  in  1  branch taken; clears all pending entries
 id_valid  in  1  ID stage holds an instruction that wants to advance
 id_dest  in  REG_AW  destination register of the ID instruction
 id_wb_en  in  1  ID instruction writes a register
 id_mem_r_en  in  1  ID instruction is a load
 src1  in  REG_AW  first source register
 src2  in  REG_AW  second source register
 two_src  in  1  src2 is used
 forward_en  in  1  forwarding unit enabled
 hazard_detected  out  1  stall ID/IF this cycle
 issue  out  1  ID instruction advances to EXE this cycle
 stall_cycles  out  16  stall statistics (see Configuration)

Function
REQ-006 SHALL keep, per register r, count[r] (CNT_W bits); r is pending when count[r] != 0.
REQ-007 SHALL assert hazard_detected combinationally when id_valid and (count[src1] != 0, or two_src and count[src2] != 0).
REQ-008 SHALL drive issue = id_valid & ~hazard_detected & ~freeze & ~flush.
REQ-009 On each rising edge with ~freeze and ~flush, SHALL decrement every nonzero count by 1, whether or not issue is asserted (bubbles still advance).
REQ-010 On an edge with issue & id_wb_en, SHALL load count[id_dest] with: WB_LAT if ~forward_en; LOAD_LAT if forward_en & id_mem_r_en; 0 if forward_en & ~id_mem_r_en.
REQ-011 When the load of REQ-010 and the decrement of REQ-009 hit the same entry on one edge, the load SHALL win.
REQ-012 When issue & ~id_wb_en, SHALL leave the table unchanged apart from REQ-009.
REQ-013 When freeze is high, SHALL hold all counts; hazard_detected still evaluates from the held counts.
REQ-014 When flush is high, SHALL set all counts to 0 on the next edge, overriding load and decrement.
REQ-015 A source equal to the destination of an instruction already in WB (count reached 0) SHALL NOT raise a hazard.
REQ-016 Latency: a producer issued at edge t SHALL block a dependent ID instruction for exactly the loaded count cycles after t, absent freeze or flush.

Reset
REQ-017 While rst is high at a rising edge, SHALL clear all counts and stall_cycles to 0; rst SHALL override flush, freeze and issue.
REQ-018 After reset, hazard_detected SHALL be 0 and issue SHALL equal id_valid & ~freeze & ~flush.
REQ-019 Reset asserted mid-stall SHALL release the stall on the first cycle after the reset edge.

Configuration
REQ-020 Macro HAZARD_STALL_STATS_EN defined: stall_cycles SHALL increment by 1 on each edge where hazard_detected & ~freeze, saturate at 16'hFFFF, and clear on rst.
REQ-021 Macro HAZARD_STALL_STATS_EN undefined: stall_cycles SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-022 forward_en=0: issue ADD with dest R3, then an instruction with src1=R3 -> hazard_detected high for 2 cycles, issue on the 3rd.
REQ-023 forward_en=1: load with dest R5, then src2=R5 with two_src=1 -> exactly 1 stall cycle; with two_src=0 -> 0 stall cycles.
REQ-024 forward_en=1: ALU op with dest R7, then src1=R7 -> no stall.
REQ-025 forward_en=0: R2 pending with count 2, freeze high for 3 cycles -> hazard stays high and the count stays 2 throughout; after freeze drops, the stall releases 2 cycles later.
REQ-026 R4 pending, flush pulses -> next cycle hazard_detected=0 for src1=R4; rst mid-stall -> same result, and stall_cycles=0.
REQ-027 With HAZARD_STALL_STATS_EN defined, run REQ-022 then REQ-023 -> stall_cycles=3.
